// File: rtl/keypad_entry.sv
// Keypad time entry: debounces one-hot key presses into three right-shifted BCD
// digits and strobes an active-low parallel load for the downstream countdown chain.
module keypad_entry #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [9:0] keypad,
  input  logic       clear_key,
  input  logic       running,
  output logic [3:0] data_mins,
  output logic [3:0] data_tens,
  output logic [3:0] data_ones,
  output logic       loadn,
  output logic       has_time,
  output logic       key_err
);

  localparam int unsigned KEY_W = 10;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] DB_CNT = CNT_W'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    LOAD,
    WAIT_RELEASE
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [KEY_W-1:0]   code_q, code_d;
  logic [3:0]         mins_q, mins_d;
  logic [3:0]         tens_q, tens_d;
  logic [3:0]         ones_q, ones_d;
  logic               loadn_q, loadn_d;
  logic               key_err_q, key_err_d;
  logic               clr_prev_q;
  logic               key_one;
  logic               clr_rise;
  logic               accept;

  // One-hot key vector to its digit value.
  function automatic logic [3:0] key_digit(input logic [KEY_W-1:0] k);
    logic [3:0] d;
    d = 4'd0;
    for (int i = 0; i < int'(KEY_W); i++) begin
      if (k[i]) d = 4'(i);
    end
    return d;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      code_q     <= '0;
      mins_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      loadn_q    <= 1'b1;
      key_err_q  <= 1'b0;
      clr_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      mins_q     <= mins_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      loadn_q    <= loadn_d;
      key_err_q  <= key_err_d;
      clr_prev_q <= clear_key;
    end
  end

  // Next-state, digit shift and strobe generation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    mins_d    = mins_q;
    tens_d    = tens_q;
    ones_d    = ones_q;
    key_err_d = 1'b0;
    accept    = 1'b0;
    key_one   = (keypad != '0) && ((keypad & (keypad - KEY_W'(1))) == '0);
    clr_rise  = clear_key && !clr_prev_q;

    case (state_q)
      IDLE: begin
        if (key_one) begin
          code_d = keypad;
          cnt_d  = CNT_W'(1);
          if (DB_CNT == CNT_W'(1)) accept = 1'b1;
          else                     state_d = DEBOUNCE;
        end else if (keypad != '0) begin
          state_d = WAIT_RELEASE;
        end
      end
      DEBOUNCE: begin
        if (keypad == code_q) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q + CNT_W'(1) == DB_CNT) accept = 1'b1;
        end else if (keypad == '0) begin
          state_d = IDLE;
        end else begin
          state_d = WAIT_RELEASE;
        end
      end
      LOAD:         state_d = WAIT_RELEASE;
      WAIT_RELEASE: if (keypad == '0) state_d = IDLE;
      default:      state_d = IDLE;
    endcase

    // A ones digit above 5 cannot legally shift into the tens position.
    if (accept) begin
      if (ones_q > 4'd5) begin
        key_err_d = 1'b1;
        state_d   = WAIT_RELEASE;
      end else begin
        mins_d  = tens_q;
        tens_d  = ones_q;
        ones_d  = key_digit(keypad);
        state_d = LOAD;
      end
    end

    if (running) begin
      state_d   = WAIT_RELEASE;
      mins_d    = mins_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      key_err_d = 1'b0;
    end else if (clr_rise) begin
      mins_d    = '0;
      tens_d    = '0;
      ones_d    = '0;
      key_err_d = 1'b0;
      state_d   = LOAD;
    end

    loadn_d = (state_d != LOAD);
  end

  assign data_mins = mins_q;
  assign data_tens = tens_q;
  assign data_ones = ones_q;
  assign loadn     = loadn_q;
  assign key_err   = key_err_q;
  assign has_time  = |{mins_q, tens_q, ones_q};

endmodule

// File: tb/tb_keypad_entry.sv
// Scoreboard bench for keypad_entry: predicted load/error events are queued at
// stimulus time and matched against each loadn/key_err pulse.
module tb_keypad_entry;

  localparam int unsigned DB = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic [9:0] keypad;
  logic       clear_key;
  logic       running;
  logic [3:0] data_mins, data_tens, data_ones;
  logic       loadn, has_time, key_err;

  typedef struct {
    bit          err;
    logic [11:0] digits;
    int unsigned cyc;
  } ev_t;

  ev_t         sb[$];
  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [3:0]  m_mins = 4'd0, m_tens = 4'd0, m_ones = 4'd0;

  keypad_entry #(.DEBOUNCE_CYCLES(DB)) dut (
    .clock(clock), .reset(reset), .keypad(keypad), .clear_key(clear_key),
    .running(running), .data_mins(data_mins), .data_tens(data_tens),
    .data_ones(data_ones), .loadn(loadn), .has_time(has_time), .key_err(key_err)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Pop one expected event for every low loadn or high key_err cycle.
  always @(negedge clock) begin
    if (!loadn || key_err) begin
      if (sb.size() == 0) begin
        check("unexpected_event", {30'd0, key_err, loadn}, 2'b01);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("event_kind_err", 32'(key_err), 32'(e.err));
        check("event_kind_loadn", 32'(loadn), 32'(e.err));
        check("event_digits", 32'({data_mins, data_tens, data_ones}), 32'(e.digits));
        check("event_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic expect_key(input int d);
    ev_t e;
    if (m_ones > 4'd5) begin
      e.err = 1'b1;
    end else begin
      e.err  = 1'b0;
      m_mins = m_tens;
      m_tens = m_ones;
      m_ones = 4'(d);
    end
    e.digits = {m_mins, m_tens, m_ones};
    e.cyc    = cyc + DB;
    sb.push_back(e);
  endtask

  task automatic press(input int d, input int hold, input int gap);
    keypad = 10'(1 << d);
    if (hold >= int'(DB) && !running) expect_key(d);
    step(hold);
    keypad = '0;
    step(gap);
  endtask

  task automatic do_clear();
    ev_t e;
    clear_key = 1'b1;
    if (!running) begin
      m_mins = 4'd0; m_tens = 4'd0; m_ones = 4'd0;
      e.err = 1'b0; e.digits = 12'd0; e.cyc = cyc + 1;
      sb.push_back(e);
    end
    step(2);
    clear_key = 1'b0;
    step(2);
  endtask

  task automatic check_digits(input string tag);
    check(tag, 32'({data_mins, data_tens, data_ones}), 32'({m_mins, m_tens, m_ones}));
    check({tag, "_has_time"}, 32'(has_time), 32'(|{m_mins, m_tens, m_ones}));
  endtask

  initial begin
    reset = 1'b1; keypad = '0; clear_key = 1'b0; running = 1'b0;
    step(3);
    reset = 1'b0;
    step(2);
    check("rst_loadn", 32'(loadn), 1);
    check("rst_key_err", 32'(key_err), 0);
    check_digits("rst_digits");

    // Three ordinary entries.
    press(1, 6, 2);
    press(3, 6, 2);
    press(0, 6, 2);
    check_digits("after_130");

    // Short bounce, then a long hold accepted once.
    press(5, 2, 2);
    press(7, 40, 2);
    check_digits("after_7");

    // Rejection with ones=7, then legal entry of 4 then 2.
    press(2, 6, 2);
    check("err_has_digits", 32'(data_ones), 7);
    do_clear();
    press(4, 6, 2);
    press(2, 6, 2);
    check_digits("after_42");

    // Two keys together are ignored silently.
    keypad = 10'b0000011000;
    step(6);
    keypad = '0;
    step(2);
    press(4, 6, 2);
    check_digits("after_multi");

    // Clear from 1/3/0.
    do_clear();
    press(1, 6, 2);
    press(3, 6, 2);
    press(0, 6, 2);
    check_digits("pre_clear");
    do_clear();
    check_digits("post_clear");

    // Running locks out keys and clear; a key held through its fall is not taken.
    running = 1'b1;
    step(1);
    press(9, 6, 2);
    do_clear();
    keypad = 10'(1 << 9);
    step(3);
    running = 1'b0;
    step(6);
    check("run_held_loadn", 32'(loadn), 1);
    keypad = '0;
    step(3);
    check_digits("after_running");

    // Reset mid-debounce.
    press(8, 6, 2);
    keypad = 10'(1 << 5);
    step(2);
    reset = 1'b1; keypad = '0;
    step(1);
    reset = 1'b0;
    m_mins = 4'd0; m_tens = 4'd0; m_ones = 4'd0;
    check("rst_db_loadn", 32'(loadn), 1);
    check_digits("rst_db_digits");
    step(6);

    // Reset in the LOAD cycle.
    keypad = 10'(1 << 6);
    expect_key(6);
    step(DB);
    reset = 1'b1; keypad = '0;
    step(1);
    reset = 1'b0;
    m_mins = 4'd0; m_tens = 4'd0; m_ones = 4'd0;
    check("rst_load_loadn", 32'(loadn), 1);
    check_digits("rst_load_digits");
    step(8);

    for (int i = 0; i < 20 && sb.size() != 0; i++) step(1);
    check("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
